// File: rtl/cpu_pkg.sv
// Shared definitions for the 7-step processor: instruction width, opcode classes,
// ALU operation codes and jump-condition bit positions.
package cpu_pkg;

  localparam int unsigned INSTR_W = 8;

  // Upper-nibble opcodes for the non-ALU classes; any byte with bit 7 set is ALU.
  localparam logic [3:0] OP_LD      = 4'h0;
  localparam logic [3:0] OP_ST      = 4'h1;
  localparam logic [3:0] OP_DATA    = 4'h2;
  localparam logic [3:0] OP_JMPR    = 4'h3;
  localparam logic [3:0] OP_JMP     = 4'h4;
  localparam logic [3:0] OP_JCOND   = 4'h5;
  localparam logic [3:0] OP_CLF     = 4'h6;
  localparam logic [3:0] OP_ILLEGAL = 4'h7;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHR = 3'b001;
  localparam logic [2:0] ALU_SHL = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam int unsigned COND_C = 3;
  localparam int unsigned COND_A = 2;
  localparam int unsigned COND_E = 1;
  localparam int unsigned COND_Z = 0;

endpackage

// File: rtl/ir_decode.sv
// Combinational instruction decoder: splits a stored instruction byte into a
// one-hot class indication plus raw operand fields.
module ir_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               is_alu,
  output logic [2:0]         alu_op,
  output logic [1:0]         reg_a,
  output logic [1:0]         reg_b,
  output logic               is_ld,
  output logic               is_st,
  output logic               is_data,
  output logic               is_jmpr,
  output logic               is_jmp,
  output logic               is_jcond,
  output logic               is_clf,
  output logic               is_illegal,
  output logic [3:0]         cond_mask
);

  logic [3:0] opcode;

  always_comb begin
    opcode     = instr[7:4];
    is_alu     = instr[7];
    alu_op     = instr[6:4];
    reg_a      = instr[3:2];
    reg_b      = instr[1:0];
    // Full-nibble compares keep bit 7 out of every non-ALU class, so the set stays one-hot.
    is_ld      = (opcode == OP_LD);
    is_st      = (opcode == OP_ST);
    is_data    = (opcode == OP_DATA);
    is_jmpr    = (opcode == OP_JMPR);
    is_jmp     = (opcode == OP_JMP);
    is_jcond   = (opcode == OP_JCOND);
    is_clf     = (opcode == OP_CLF);
    is_illegal = (opcode == OP_ILLEGAL);
    cond_mask  = {instr[COND_C], instr[COND_A], instr[COND_E], instr[COND_Z]};
  end

endmodule

// File: rtl/instruction_register.sv
// 8-bit instruction register: captures the bus byte on a set strobe and presents
// the stored byte together with its decoded fields to the control section.
module instruction_register
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s,
  input  logic [INSTR_W-1:0] i_in,
  output logic [INSTR_W-1:0] i_out,
  output logic               is_alu,
  output logic [2:0]         alu_op,
  output logic [1:0]         reg_a,
  output logic [1:0]         reg_b,
  output logic               is_ld,
  output logic               is_st,
  output logic               is_data,
  output logic               is_jmpr,
  output logic               is_jmp,
  output logic               is_jcond,
  output logic               is_clf,
  output logic               is_illegal,
  output logic [3:0]         cond_mask
);

  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] ir_d;

  always_comb begin
    ir_d = ir_q;
    if (s) begin
      ir_d = i_in;
    end
  end

  // Reset takes priority over the load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= RESET_VAL;
    end else begin
      ir_q <= ir_d;
    end
  end

  assign i_out = ir_q;

  // Decode from the stored byte only, so fields change just after a clock edge.
  ir_decode u_ir_decode (
    .instr      (ir_q),
    .is_alu     (is_alu),
    .alu_op     (alu_op),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_data    (is_data),
    .is_jmpr    (is_jmpr),
    .is_jmp     (is_jmp),
    .is_jcond   (is_jcond),
    .is_clf     (is_clf),
    .is_illegal (is_illegal),
    .cond_mask  (cond_mask)
  );

endmodule

// File: tb/tb_instruction_register.sv
// Bench for instruction_register: directed steps plus random bus traffic, checked
// against a byte-level model of the register and its decode rules.
module tb_instruction_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       s;
  logic [7:0] i_in;
  logic [7:0] i_out;
  logic       is_alu, is_ld, is_st, is_data, is_jmpr, is_jmp, is_jcond, is_clf, is_illegal;
  logic [2:0] alu_op;
  logic [1:0] reg_a, reg_b;
  logic [3:0] cond_mask;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model_ir;
  bit         model_valid = 1'b0;

  always #5 clk = ~clk;

  instruction_register #(.RESET_VAL(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s),
    .i_in       (i_in),
    .i_out      (i_out),
    .is_alu     (is_alu),
    .alu_op     (alu_op),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_data    (is_data),
    .is_jmpr    (is_jmpr),
    .is_jmp     (is_jmp),
    .is_jcond   (is_jcond),
    .is_clf     (is_clf),
    .is_illegal (is_illegal),
    .cond_mask  (cond_mask)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit 0 = ALU class, bit 1+n = non-ALU opcode n.
  function automatic logic [8:0] class_of(input logic [7:0] b);
    if (b >= 8'h80) return 9'd1;
    return 9'd1 << (int'(b) / 16 + 1);
  endfunction

  task automatic check_all(input string ctx);
    logic [8:0] flags;
    flags = {is_illegal, is_clf, is_jcond, is_jmp, is_jmpr, is_data, is_st, is_ld, is_alu};
    check({ctx, ".i_out"}, {8'h00, i_out}, {8'h00, model_ir});
    check({ctx, ".class"}, {7'h00, flags}, {7'h00, class_of(model_ir)});
    check({ctx, ".onehot"}, {15'h0, $onehot(flags)}, 16'h1);
    check({ctx, ".alu_op"}, {13'h0, alu_op}, 16'((int'(model_ir) / 16) % 8));
    check({ctx, ".reg_a"}, {14'h0, reg_a}, 16'((int'(model_ir) / 4) % 4));
    check({ctx, ".reg_b"}, {14'h0, reg_b}, 16'(int'(model_ir) % 4));
    check({ctx, ".cond"}, {12'h0, cond_mask}, 16'(int'(model_ir) % 16));
  endtask

  // Drive inputs, confirm nothing moves before the edge, then check after the edge.
  task automatic step(input logic r, input logic sv, input logic [7:0] d, input string ctx);
    rst  = r;
    s    = sv;
    i_in = d;
    #1;
    if (model_valid) check_all({ctx, ".pre"});
    @(posedge clk);
    if (r) model_ir = 8'h00;
    else if (sv) model_ir = d;
    if (r || sv) model_valid = 1'b1;
    #1;
    if (model_valid) check_all(ctx);
  endtask

  initial begin
    logic [7:0] sweep [9];
    sweep = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    rst  = 1'b0;
    s    = 1'b0;
    i_in = 8'h00;

    step(1'b1, 1'b1, 8'hFF, "reset0");
    step(1'b1, 1'b1, 8'hFF, "reset1");
    check("reset.is_ld", {15'h0, is_ld}, 16'h1);

    step(1'b0, 1'b0, 8'hAA, "aa_hold0");
    step(1'b0, 1'b0, 8'hAA, "aa_hold1");
    step(1'b0, 1'b1, 8'hAA, "aa_load");
    check("aa.is_alu", {15'h0, is_alu}, 16'h1);
    check("aa.alu_op", {13'h0, alu_op}, 16'h2);
    check("aa.reg_a", {14'h0, reg_a}, 16'h2);
    step(1'b0, 1'b0, 8'h3C, "aa_keep");

    step(1'b0, 1'b0, 8'h55, "x55_hold");
    step(1'b0, 1'b1, 8'h55, "x55_load");
    check("x55.is_jcond", {15'h0, is_jcond}, 16'h1);
    check("x55.cond", {12'h0, cond_mask}, 16'h5);

    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'($urandom), "noise");

    foreach (sweep[i]) begin
      step(1'b0, 1'b1, sweep[i], "sweep_load");
      step(1'b0, 1'b0, 8'($urandom), "sweep_hold");
    end

    step(1'b0, 1'b1, 8'h01, "stream1");
    step(1'b0, 1'b1, 8'h02, "stream2");
    step(1'b0, 1'b1, 8'h03, "stream3");
    step(1'b1, 1'b1, 8'h04, "stream_rst");
    step(1'b0, 1'b1, 8'h05, "stream5");

    for (int i = 0; i < 300; i++) begin
      step(($urandom % 16) == 0, 1'($urandom), 8'($urandom), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
